// File: rtl/ram_writer.sv
// ---------------------------------------------------------------------------
// ram_writer
//
// Streaming AXI3 write master. Beats from an unstallable AXI-Stream source
// are buffered in a small first-word-fall-through FIFO. Whenever a full
// burst's worth of beats is buffered, the block issues one INCR burst into a
// DDR ring buffer of 2^RW_log_length bursts starting at RW_base_address.
// After each burst that completes with an OKAY response, the burst's start
// address is published on SM_address with a one-cycle SM_request pulse. That
// lets the downstream sync manager always know where the newest data lives.
//
// Ports:
//   SYS_aclk, SYS_aresetn       clock, asynchronous active-low reset
//   RW_enable                   capture/write enable (stops after the current burst)
//   RW_base_address             ring base, aligned to the ring size
//   RW_log_length               log2 of the ring size in bursts
//   RW_error                    sticky flag, set by any non-OKAY write response
//   S_AXIS_*                    sample stream in (tready is constant 1)
//   M_AXI_aw* / w* / b*         AXI3 write channels (one transaction in flight)
//   SM_request                  one-cycle pulse per successful burst
//   SM_address                  start address of the last successful burst
//   SM_log_length               RW_log_length latched at burst start
//   RW_overflow_count           dropped-beat counter, saturating at 2^32-1
//                               (present only when the macro below is defined)
//
// Optional feature: define RAM_WRITER_OVERFLOW_COUNT_EN to add
// RW_overflow_count. Without the macro, dropped beats are silent.
// ---------------------------------------------------------------------------
module ram_writer #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int MM_DATA_WIDTH = 64,
  parameter int BURST_LEN     = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                         SYS_aclk,
  input  logic                         SYS_aresetn,
  input  logic                         RW_enable,
  input  logic [MM_ADDR_WIDTH-1:0]     RW_base_address,
  input  logic [4:0]                   RW_log_length,
  output logic                         RW_error,
  input  logic [MM_DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                         S_AXIS_tvalid,
  output logic                         S_AXIS_tready,
  output logic [MM_ADDR_WIDTH-1:0]     M_AXI_awaddr,
  output logic [3:0]                   M_AXI_awlen,
  output logic [2:0]                   M_AXI_awsize,
  output logic [1:0]                   M_AXI_awburst,
  output logic                         M_AXI_awvalid,
  input  logic                         M_AXI_awready,
  output logic [MM_DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [MM_DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                         M_AXI_wlast,
  output logic                         M_AXI_wvalid,
  input  logic                         M_AXI_wready,
  input  logic [1:0]                   M_AXI_bresp,
  input  logic                         M_AXI_bvalid,
  output logic                         M_AXI_bready,
  output logic                         SM_request,
  output logic [MM_ADDR_WIDTH-1:0]     SM_address,
`ifdef RAM_WRITER_OVERFLOW_COUNT_EN
  output logic [31:0]                  RW_overflow_count,
`endif
  output logic [4:0]                   SM_log_length
);

  localparam int BYTES_PER_BEAT = MM_DATA_WIDTH / 8;
  localparam int AWSIZE_VAL     = $clog2(BYTES_PER_BEAT);
  localparam int BURST_SHIFT    = $clog2(BURST_LEN * BYTES_PER_BEAT);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;

  localparam logic [4:0]       LAST_BEAT = 5'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [MM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     fifo_full_s;
  logic                     push_s;
  logic                     pop_s;

  // Burst control
  state_t                   state_q, state_d;
  logic [4:0]               beat_q, beat_d;
  logic [25:0]              idx_q, idx_d;
  logic [25:0]              ring_mask_s;
  logic [4:0]               ring_log_s;
  logic [MM_ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;

  // Registered outputs
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     wlast_q, wlast_d;
  logic                     bready_q, bready_d;
  logic                     sm_request_q, sm_request_d;
  logic [MM_ADDR_WIDTH-1:0] sm_address_q, sm_address_d;
  logic [4:0]               sm_log_q, sm_log_d;
  logic                     error_q, error_d;

  // FIFO push/pop decisions and pointer/count updates.
  always_comb begin
    fifo_full_s = (count_q == FULL_CNT);
    push_s      = S_AXIS_tvalid && RW_enable && !fifo_full_s;
    // W is only valid in DATA, and a burst only starts with enough data
    // buffered, so a pop never hits an empty FIFO.
    pop_s       = wvalid_q && M_AXI_wready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    unique case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port; contents need no reset.
  always_ff @(posedge SYS_aclk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q] <= S_AXIS_tdata;
    end
  end

  // Ring index mask: L = min(RW_log_length, 26). At L = 26 the shift
  // overflows to 0 and the subtraction yields all ones, as wanted.
  always_comb begin
    if (RW_log_length > 5'd26) begin
      ring_log_s = 5'd26;
    end else begin
      ring_log_s = RW_log_length;
    end
    ring_mask_s = (26'd1 << ring_log_s) - 26'd1;
  end

  // Burst FSM next state, completion bookkeeping and next-cycle outputs.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    idx_d        = idx_q;
    burst_addr_d = burst_addr_q;
    sm_log_d     = sm_log_q;
    sm_address_d = sm_address_q;
    sm_request_d = 1'b0;
    error_d      = error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (RW_enable && (count_q >= BURST_CNT)) begin
          state_d      = ST_ADDR;
          burst_addr_d = RW_base_address
                       + (MM_ADDR_WIDTH'(idx_q & ring_mask_s) << BURST_SHIFT);
          sm_log_d     = RW_log_length;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (M_AXI_awready) begin
          state_d = ST_DATA;
          beat_d  = 5'd0;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (M_AXI_wready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_RESP;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        if (M_AXI_bvalid) begin
          state_d = ST_IDLE;
          // The index advances even on error so the ring slot is skipped.
          idx_d   = (idx_q + 26'd1) & ring_mask_s;
          if (M_AXI_bresp == 2'b00) begin
            sm_request_d = 1'b1;
            sm_address_d = burst_addr_q;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    awvalid_d = (state_d == ST_ADDR);
    wvalid_d  = (state_d == ST_DATA);
    wlast_d   = (state_d == ST_DATA) && (beat_d == LAST_BEAT);
    bready_d  = (state_d == ST_RESP);
  end

  // State, pointers and registered outputs.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      beat_q       <= 5'd0;
      idx_q        <= 26'd0;
      burst_addr_q <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      sm_request_q <= 1'b0;
      sm_address_q <= '0;
      sm_log_q     <= 5'd0;
      error_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      beat_q       <= beat_d;
      idx_q        <= idx_d;
      burst_addr_q <= burst_addr_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      bready_q     <= bready_d;
      sm_request_q <= sm_request_d;
      sm_address_q <= sm_address_d;
      sm_log_q     <= sm_log_d;
      error_q      <= error_d;
    end
  end

`ifdef RAM_WRITER_OVERFLOW_COUNT_EN
  logic        drop_s;
  logic [31:0] ovf_q, ovf_d;

  // Saturating count of beats lost to a full FIFO.
  always_comb begin
    drop_s = S_AXIS_tvalid && RW_enable && fifo_full_s;
    if (drop_s && (ovf_q != 32'hFFFF_FFFF)) begin
      ovf_d = ovf_q + 32'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow counter register.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      ovf_q <= 32'd0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign RW_overflow_count = ovf_q;
`endif

  assign S_AXIS_tready = 1'b1;
  assign M_AXI_awaddr  = burst_addr_q;
  assign M_AXI_awlen   = 4'(BURST_LEN - 1);
  assign M_AXI_awsize  = 3'(AWSIZE_VAL);
  assign M_AXI_awburst = 2'b01;
  assign M_AXI_awvalid = awvalid_q;
  // First-word-fall-through: the head entry is always presented.
  assign M_AXI_wdata   = fifo_mem[rd_ptr_q];
  assign M_AXI_wstrb   = {BYTES_PER_BEAT{1'b1}};
  assign M_AXI_wlast   = wlast_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign SM_request    = sm_request_q;
  assign SM_address    = sm_address_q;
  assign SM_log_length = sm_log_q;
  assign RW_error      = error_q;

endmodule

// File: tb/tb_ram_writer.sv
// Testbench for ram_writer: directed sequence of scenarios with randomized
// stream data, checked against a beat-queue reference model of the ring writer.
module tb_ram_writer;

  localparam int BL = 8;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rw_enable = 1'b0;
  logic [31:0] rw_base = 32'h1000_0000;
  logic [4:0]  rw_log = 5'd3;
  logic        rw_error;
  logic [63:0] s_tdata = 64'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b1;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b1;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        sm_request;
  logic [31:0] sm_address;
  logic [4:0]  sm_log_length;
`ifdef RAM_WRITER_OVERFLOW_COUNT_EN
  logic [31:0] ovf_count;
`endif

  ram_writer #(
    .MM_ADDR_WIDTH(32), .MM_DATA_WIDTH(64), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .SYS_aclk(clk), .SYS_aresetn(rst_n),
    .RW_enable(rw_enable), .RW_base_address(rw_base), .RW_log_length(rw_log),
    .RW_error(rw_error),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .M_AXI_awaddr(awaddr), .M_AXI_awlen(awlen), .M_AXI_awsize(awsize),
    .M_AXI_awburst(awburst), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wlast(wlast),
    .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .SM_request(sm_request), .SM_address(sm_address),
`ifdef RAM_WRITER_OVERFLOW_COUNT_EN
    .RW_overflow_count(ovf_count),
`endif
    .SM_log_length(sm_log_length)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [63:0] q[$];
  int          bursts_done = 0;
  int          beat = 0;
  bit          b_pending = 0;
  bit          sm_exp = 0;
  logic [31:0] sm_addr_exp = 32'd0;
  logic [31:0] cur_aw_addr = 32'd0;
  bit          err_exp = 0;
  int          drops = 0;

  // Stimulus controls
  int          feed_left = 0;
  int          feed_pct = 100;
  bit          seq_mode = 0;
  int          seq_val = 0;
  int          aw_hold = 0;
  bit          w_toggle = 0;
  int          err_at = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ring slot address of the next burst: base + (n mod 2^L) * bytes-per-burst.
  function automatic logic [31:0] exp_addr();
    int     l;
    longint ring;
    l    = (rw_log > 5'd26) ? 26 : int'(rw_log);
    ring = longint'(1) << l;
    return rw_base + 32'((longint'(bursts_done) % ring) * (BL * 8));
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cyc();
    bit aw_hs, w_hs, b_hs, was_full;
    if (feed_left > 0 && int'($urandom_range(0, 99)) < feed_pct) begin
      s_tvalid = 1'b1;
      s_tdata  = seq_mode ? 64'(seq_val) : {$urandom, $urandom};
      if (seq_mode) seq_val++;
      feed_left--;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = {$urandom, $urandom};
    end
    if (aw_hold > 0) begin
      awready = 1'b0;
      aw_hold--;
    end else begin
      awready = 1'b1;
    end
    wready = w_toggle ? ~wready : 1'b1;
    bvalid = b_pending;
    bresp  = (bursts_done == err_at) ? 2'b10 : 2'b00;

    chk("sm_request", 64'(sm_request), 64'(sm_exp));
    chk("sm_address", 64'(sm_address), 64'(sm_addr_exp));
    chk("rw_error", 64'(rw_error), 64'(err_exp));
    chk("bready", 64'(bready), 64'(b_pending));
    chk("tready", 64'(s_tready), 64'd1);
`ifdef RAM_WRITER_OVERFLOW_COUNT_EN
    chk("overflow_count", 64'(ovf_count), 64'(drops));
`endif
    if (sm_exp) chk("sm_log_length", 64'(sm_log_length), 64'(rw_log));
    if (awvalid === 1'b1) begin
      chk("awaddr", 64'(awaddr), 64'(exp_addr()));
      chk("awlen", 64'(awlen), 64'(BL - 1));
      chk("awsize", 64'(awsize), 64'd3);
      chk("awburst", 64'(awburst), 64'd1);
    end
    if (wvalid === 1'b1) begin
      if (q.size() == 0) begin
        chk("wvalid_without_data", 64'(wvalid), 64'd0);
      end else begin
        chk("wdata", wdata, q[0]);
      end
      chk("wlast", 64'(wlast), 64'(beat == BL - 1));
      chk("wstrb", 64'(wstrb), 64'hFF);
    end

    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    b_hs     = bvalid && bready;
    was_full = (q.size() >= FD);
    sm_exp   = 0;
    if (b_hs) begin
      if (bresp == 2'b00) begin
        sm_exp      = 1;
        sm_addr_exp = cur_aw_addr;
      end else begin
        err_exp = 1;
      end
      bursts_done++;
      b_pending = 0;
    end
    if (aw_hs) begin
      cur_aw_addr = exp_addr();
      beat = 0;
    end
    if (w_hs && q.size() > 0) begin
      void'(q.pop_front());
      if (beat == BL - 1) b_pending = 1;
      beat++;
    end
    if (s_tvalid && rw_enable) begin
      if (was_full) drops++;
      else q.push_back(s_tdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    bvalid = 1'b0;
    #1;
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_sm_request", 64'(sm_request), 64'd0);
    chk("rst_sm_address", 64'(sm_address), 64'd0);
    chk("rst_sm_log_length", 64'(sm_log_length), 64'd0);
    chk("rst_rw_error", 64'(rw_error), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd1);
`ifdef RAM_WRITER_OVERFLOW_COUNT_EN
    chk("rst_overflow_count", 64'(ovf_count), 64'd0);
`endif
    q.delete();
    bursts_done = 0; beat = 0; b_pending = 0; sm_exp = 0;
    sm_addr_exp = 32'd0; cur_aw_addr = 32'd0; err_exp = 0; drops = 0;
    feed_left = 0; aw_hold = 0; w_toggle = 0; err_at = -1; seq_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Run until the stream is fed, fewer than a burst remains and the bus is idle.
  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && !(feed_left == 0 && q.size() < BL &&
                           !awvalid && !wvalid && !bready)) begin
      cyc();
      n++;
    end
    chk("drain_deadline", 64'(n < budget), 64'd1);
    repeat (2) cyc();
  endtask

  initial begin
    #2;
    rw_enable = 1'b1;
    rw_base = 32'h1000_0000;
    rw_log = 5'd3;
    apply_reset();

    // Basic burst: values 0..7
    seq_mode = 1; seq_val = 0; feed_pct = 100; feed_left = 8;
    drain(200);
    chk("basic_bursts", 64'(bursts_done), 64'd1);
    chk("basic_sm_address", 64'(sm_address), 64'h1000_0000);
    chk("basic_sm_log", 64'(sm_log_length), 64'd3);

    // Ring wrap: eight more bursts, the last one back at base
    seq_mode = 0; feed_pct = 50; feed_left = 64;
    drain(1000);
    chk("wrap_bursts", 64'(bursts_done), 64'd9);
    chk("wrap_sm_address", 64'(sm_address), 64'h1000_0000);

    // Backpressure: AW held off, W toggling, continuous stream
    aw_hold = 10; w_toggle = 1; feed_pct = 50; feed_left = 24;
    drain(1000);
    w_toggle = 0;
    chk("bp_bursts", 64'(bursts_done), 64'd12);

    // Overflow with a single-slot ring at a different base
    rw_base = 32'h2000_0000;
    rw_log = 5'd0;
    apply_reset();
    aw_hold = 1000; feed_pct = 100; feed_left = 20;
    repeat (30) cyc();
`ifdef RAM_WRITER_OVERFLOW_COUNT_EN
    chk("overflow_four", 64'(ovf_count), 64'd4);
`endif
    aw_hold = 0;
    drain(200);
    chk("ovf_bursts", 64'(bursts_done), 64'd2);
    chk("ovf_sm_address", 64'(sm_address), 64'h2000_0000);

    // Error response on the second burst
    rw_base = 32'h1000_0000;
    rw_log = 5'd3;
    apply_reset();
    err_at = 1; feed_pct = 100; feed_left = 24;
    drain(500);
    chk("err_bursts", 64'(bursts_done), 64'd3);
    chk("err_sticky", 64'(rw_error), 64'd1);
    chk("err_sm_address", 64'(sm_address), 64'h1000_0080);
    err_at = -1;

    // Disable during beat 3, then a mid-burst reset
    apply_reset();
    aw_hold = 1000; feed_pct = 100; feed_left = 16;
    repeat (20) cyc();
    aw_hold = 0;
    for (int n = 0; n < 100 && !(beat == 3 && wvalid); n++) cyc();
    chk("reached_beat3", 64'(beat), 64'd3);
    rw_enable = 1'b0;
    for (int n = 0; n < 100 && bursts_done < 1; n++) cyc();
    chk("disable_first_done", 64'(bursts_done), 64'd1);
    for (int n = 0; n < 20; n++) begin
      cyc();
      chk("no_aw_when_disabled", 64'(awvalid), 64'd0);
    end
    rw_enable = 1'b1;
    drain(200);
    chk("disable_bursts", 64'(bursts_done), 64'd2);
    feed_left = 8;
    for (int n = 0; n < 100 && !wvalid; n++) cyc();
    chk("midburst_wvalid", 64'(wvalid), 64'd1);
    repeat (2) cyc();
    apply_reset();
    feed_left = 8;
    drain(200);
    chk("after_reset_bursts", 64'(bursts_done), 64'd1);
    chk("after_reset_sm_address", 64'(sm_address), 64'h1000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
